// File: rtl/falling_cubes_pkg.sv
// rtl/falling_cubes_pkg.sv - shared constants, colours and FSM state type for falling_cubes_gen
// Contents:
//   geometry constants (cube, paddle, screen), colour codes {R,G,B},
//   game FSM state type, cube start-position and respawn-position helpers.
package falling_cubes_pkg;

  localparam int N_CUBES = 4;

  localparam logic [9:0] CUBE_SIZE    = 10'd16;
  localparam logic [9:0] PADDLE_W     = 10'd64;
  localparam logic [9:0] PADDLE_Y     = 10'd448;
  localparam logic [9:0] PADDLE_Y_END = 10'd456;  // paddle is 8 rows tall
  localparam logic [9:0] PADDLE_STEP  = 10'd4;
  localparam logic [9:0] PADDLE_X0    = 10'd288;
  localparam logic [9:0] PADDLE_X_MAX = 10'd576;
  localparam logic [9:0] FRAME_Y      = 10'd480;  // first blanking line
  localparam logic [1:0] MAX_MISSES   = 2'd3;

  localparam logic [2:0] COL_OFF    = 3'b000;
  localparam logic [2:0] COL_PADDLE = 3'b010;
  localparam logic [2:0] COL_CUBE   = 3'b100;
  localparam logic [2:0] COL_BG     = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  function automatic logic [9:0] cube_x0(input int i);
    return 10'(64 + 128 * i);
  endfunction

  // Each cube looks at a different rotation of the LFSR so that cubes
  // respawning in the same frame land at different columns.
  function automatic logic [9:0] respawn_x(input logic [9:0] v, input int n);
    logic [9:0] r;
    r = (n == 0) ? v : ((v << n) | (v >> (10 - n)));
    return {1'b0, r[8:0]} + 10'd64;
  endfunction

endpackage

// File: rtl/falling_cubes_gen_lfsr10.sv
// rtl/falling_cubes_gen_lfsr10.sv - free-running 10-bit maximal-length Fibonacci LFSR
// Ports:
//   clk   - system clock
//   reset - synchronous, active-low; loads 10'h001
//   q     - current LFSR state
module lfsr10 (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] q
);

  logic [9:0] q_q;

  // Polynomial x^10 + x^7 + 1 gives a period of 1023.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= 10'h001;
    end else begin
      q_q <= {q_q[8:0], q_q[9] ^ q_q[6]};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/falling_cubes_gen.sv
// rtl/falling_cubes_gen.sv - falling-cubes catch game: frame-rate game state plus pixel colour generator
// Ports:
//   clk, reset                    - clock, synchronous active-low reset
//   p_tick                        - pixel enable (not needed: frame detection and rgb run every clk)
//   video_on, pixel_x, pixel_y    - VGA scan position
//   btn_left, btn_right, btn_start- debounced level buttons
//   rgb                           - registered pixel colour {R,G,B}
//   score                         - caught cubes, saturating at 255
//   game_over                     - high while the game is in OVER
module falling_cubes_gen
  import falling_cubes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [2:0] rgb,
  output logic [7:0] score,
  output logic       game_over
);

  state_t                     state_q;
  logic [2:0]                 rgb_q, rgb_d;
  logic [7:0]                 score_q, score_d;
  logic [1:0]                 misses_q, misses_d;
  logic [9:0]                 paddle_x_q, paddle_x_d;
  logic [N_CUBES-1:0][9:0]    cube_x_q, cube_x_d;
  logic [N_CUBES-1:0][9:0]    cube_y_q, cube_y_d;
  logic [N_CUBES-1:0][9:0]    ny;
  logic [N_CUBES-1:0]         catch_v, miss_v, in_cube;
  logic [2:0]                 n_catch, n_miss, miss_sum;
  logic [8:0]                 score_sum;
  logic [9:0]                 prev_y_q;
  logic                       armed_q;
  logic                       frame_tick;
  logic                       load_game;
  logic                       in_paddle;
  logic [9:0]                 lfsr_q;
  logic                       unused_p_tick;

  assign unused_p_tick = p_tick;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // armed_q suppresses a spurious tick on the first cycle after reset
  // release when pixel_y already sits on line 480.
  assign frame_tick = armed_q && (pixel_y == FRAME_Y) && (prev_y_q != FRAME_Y);
  assign load_game  = (state_q != ST_PLAY) && btn_start;

  // Next-frame game state. Catch detection uses the paddle position after
  // this frame's move so the picture and the collision agree.
  always_comb begin
    paddle_x_d = paddle_x_q;
    if (btn_left && !btn_right) begin
      paddle_x_d = (paddle_x_q >= PADDLE_STEP) ? paddle_x_q - PADDLE_STEP : '0;
    end else if (btn_right && !btn_left) begin
      paddle_x_d = (paddle_x_q >= PADDLE_X_MAX - PADDLE_STEP) ? PADDLE_X_MAX
                                                               : paddle_x_q + PADDLE_STEP;
    end

    n_catch  = '0;
    n_miss   = '0;
    cube_x_d = cube_x_q;
    cube_y_d = cube_y_q;
    for (int i = 0; i < N_CUBES; i++) begin
      ny[i]      = cube_y_q[i] + 10'(i + 1);
      catch_v[i] = (ny[i] + CUBE_SIZE >= PADDLE_Y) && (ny[i] < PADDLE_Y_END) &&
                   (cube_x_q[i] < paddle_x_d + PADDLE_W) &&
                   (cube_x_q[i] + CUBE_SIZE > paddle_x_d);
      miss_v[i]  = !catch_v[i] && (ny[i] >= FRAME_Y);
      if (catch_v[i] || miss_v[i]) begin
        cube_x_d[i] = respawn_x(lfsr_q, 3 * i);
        cube_y_d[i] = '0;
      end else begin
        cube_y_d[i] = ny[i];
      end
      n_catch = n_catch + {2'b00, catch_v[i]};
      n_miss  = n_miss + {2'b00, miss_v[i]};
    end

    score_sum = {1'b0, score_q} + {6'b0, n_catch};
    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
    miss_sum  = {1'b0, misses_q} + n_miss;
    misses_d  = (miss_sum >= {1'b0, MAX_MISSES}) ? MAX_MISSES : miss_sum[1:0];
  end

  // Pixel colour; paddle wins over cubes.
  always_comb begin
    in_paddle = (pixel_y >= PADDLE_Y) && (pixel_y < PADDLE_Y_END) &&
                (pixel_x >= paddle_x_q) && (pixel_x < paddle_x_q + PADDLE_W);
    for (int i = 0; i < N_CUBES; i++) begin
      in_cube[i] = (pixel_x >= cube_x_q[i]) && (pixel_x < cube_x_q[i] + CUBE_SIZE) &&
                   (pixel_y >= cube_y_q[i]) && (pixel_y < cube_y_q[i] + CUBE_SIZE);
    end
    if (!video_on)       rgb_d = COL_OFF;
    else if (in_paddle)  rgb_d = COL_PADDLE;
    else if (|in_cube)   rgb_d = COL_CUBE;
    else                 rgb_d = COL_BG;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      rgb_q    <= COL_OFF;
      prev_y_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      prev_y_q <= pixel_y;
      armed_q  <= 1'b1;
      case (state_q)
        ST_IDLE, ST_OVER: if (btn_start) state_q <= ST_PLAY;
        ST_PLAY:          if (frame_tick && misses_d == MAX_MISSES) state_q <= ST_OVER;
        default:          state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || load_game) begin
      score_q    <= '0;
      misses_q   <= '0;
      paddle_x_q <= PADDLE_X0;
      cube_y_q   <= '0;
      for (int i = 0; i < N_CUBES; i++) cube_x_q[i] <= cube_x0(i);
    end else if (state_q == ST_PLAY && frame_tick) begin
      score_q    <= score_d;
      misses_q   <= misses_d;
      paddle_x_q <= paddle_x_d;
      cube_x_q   <= cube_x_d;
      cube_y_q   <= cube_y_d;
    end
  end

  assign rgb       = rgb_q;
  assign score     = score_q;
  assign game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_falling_cubes_gen.sv
// tb/tb_falling_cubes_gen.sv - directed self-checking bench for falling_cubes_gen
module tb_falling_cubes_gen;
  import falling_cubes_pkg::*;

  logic       clk = 1'b0;
  logic       reset, p_tick, video_on, btn_left, btn_right, btn_start;
  logic [9:0] pixel_x, pixel_y;
  logic [2:0] rgb;
  logic [7:0] score;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  falling_cubes_gen dut (
    .clk       (clk),
    .reset     (reset),
    .p_tick    (p_tick),
    .video_on  (video_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_start (btn_start),
    .rgb       (rgb),
    .score     (score),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      pixel_y = 10'd480;
      step();
      pixel_y = 10'd0;
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(); step(); step();
    reset = 1'b1;
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic von, input int exp, input string tag);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    step();
    chk(tag, int'(rgb), exp);
  endtask

  initial begin
    reset = 1'b0; p_tick = 1'b1; video_on = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_start = 1'b0;
    pixel_x = '0; pixel_y = 10'd480;

    // reset held 3 clk with pixel_y parked on the tick line
    step(); step(); step();
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_lfsr", int'(dut.u_lfsr.q), 1);
    reset = 1'b1;
    chk("no_tick_after_release", int'(dut.frame_tick), 0);
    step();
    chk("lfsr_step", int'(dut.u_lfsr.q), 2);
    pixel_y = '0;
    chk("idle_state", int'(dut.state_q), int'(ST_IDLE));
    chk("idle_score", int'(score), 0);
    chk("idle_game_over", int'(game_over), 0);

    pix(100, 100, 1'b1, 1, "rgb_bg");
    pix(700, 100, 1'b0, 0, "rgb_blank");
    pix(70, 5, 1'b1, 4, "rgb_cube0");
    pix(300, 450, 1'b1, 2, "rgb_paddle");
    video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    frames(2);
    chk("idle_frozen_y0", int'(dut.cube_y_q[0]), 0);

    // start and fall 10 frames
    press_start();
    chk("play_state", int'(dut.state_q), int'(ST_PLAY));
    frames(10);
    chk("f10_cube3_y", int'(dut.cube_y_q[3]), 40);
    chk("f10_cube0_y", int'(dut.cube_y_q[0]), 10);
    chk("f10_cube1_y", int'(dut.cube_y_q[1]), 20);
    chk("f10_paddle", int'(dut.paddle_x_q), 288);
    pix(450, 45, 1'b1, 4, "rgb_cube3");
    video_on = 1'b0; pixel_y = '0;
    press_start();
    chk("start_ignored_in_play", int'(dut.cube_y_q[0]), 10);

    // right clamp, then both buttons
    btn_right = 1'b1; frames(80); btn_right = 1'b0;
    chk("right_clamp", int'(dut.paddle_x_q), 576);
    btn_left = 1'b1; btn_right = 1'b1; frames(2); btn_left = 1'b0; btn_right = 1'b0;
    chk("both_no_move", int'(dut.paddle_x_q), 576);
    chk("f92_misses", int'(dut.misses_q), 0);
    pix(639, 450, 1'b1, 2, "rgb_paddle_right_edge");
    pix(575, 450, 1'b1, 1, "rgb_left_of_paddle");
    video_on = 1'b0; pixel_y = '0;

    // left clamp, then miss out with the paddle parked at 0
    do_reset();
    chk("rst2_paddle", int'(dut.paddle_x_q), 288);
    press_start();
    btn_left = 1'b1; frames(80); btn_left = 1'b0;
    chk("left_clamp", int'(dut.paddle_x_q), 0);
    frames(159);
    chk("f239_misses", int'(dut.misses_q), 2);
    chk("f239_game_over", int'(game_over), 0);
    frames(1);
    chk("f240_game_over", int'(game_over), 1);
    chk("f240_misses_sat", int'(dut.misses_q), 3);
    chk("f240_state", int'(dut.state_q), int'(ST_OVER));
    chk("f240_score", int'(score), 0);
    chk("f240_cube0_y", int'(dut.cube_y_q[0]), 240);
    btn_right = 1'b1; frames(5); btn_right = 1'b0;
    chk("over_frozen_y0", int'(dut.cube_y_q[0]), 240);
    chk("over_frozen_paddle", int'(dut.paddle_x_q), 0);
    press_start();
    chk("restart_game_over", int'(game_over), 0);
    chk("restart_score", int'(score), 0);
    chk("restart_misses", int'(dut.misses_q), 0);
    chk("restart_cube0_y", int'(dut.cube_y_q[0]), 0);
    chk("restart_paddle", int'(dut.paddle_x_q), 288);

    // paddle edge at 256 only touches cube 2 (x=320): no catch
    btn_left = 1'b1; frames(8); btn_left = 1'b0;
    chk("p256_paddle", int'(dut.paddle_x_q), 256);
    frames(136);
    chk("p256_cube2_not_caught", int'(dut.cube_y_q[2]), 432);
    chk("p256_score", int'(score), 0);

    // paddle at 288 overlaps cube 2: caught at frame 144
    do_reset();
    press_start();
    frames(143);
    chk("f143_score", int'(score), 0);
    chk("f143_cube2_y", int'(dut.cube_y_q[2]), 429);
    frames(1);
    chk("f144_score", int'(score), 1);
    chk("f144_cube2_y", int'(dut.cube_y_q[2]), 0);
    chk("f144_misses", int'(dut.misses_q), 1);

    // reset mid-frame during PLAY
    pixel_x = 10'd100; pixel_y = 10'd200; video_on = 1'b1;
    reset = 1'b0;
    step();
    chk("midrst_rgb", int'(rgb), 0);
    chk("midrst_state", int'(dut.state_q), int'(ST_IDLE));
    chk("midrst_score", int'(score), 0);
    chk("midrst_misses", int'(dut.misses_q), 0);
    chk("midrst_cube1_y", int'(dut.cube_y_q[1]), 0);
    chk("midrst_paddle", int'(dut.paddle_x_q), 288);
    reset = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
